// File: rtl/apu_dma_pkg.sv
// Shared types and constants for the APU bus-master sequencer
// (sprite OAM DMA and DPCM sample fetch).
package apu_dma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HALT   = 3'd1,
        ALIGN  = 3'd2,
        SPR_RD = 3'd3,
        SPR_WR = 3'd4,
        DMC_RD = 3'd5
    } dma_state_t;

    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam logic [7:0]  SPR_LAST     = 8'hFF;

    // Which read state a get cycle starts: DPCM fetches always win over sprite reads.
    function automatic dma_state_t read_choice(input logic dmc_ok, input logic spr_pend);
        dma_state_t s;
        s = IDLE;
        if (dmc_ok)
            s = DMC_RD;
        else if (spr_pend)
            s = SPR_RD;
        return s;
    endfunction

endpackage

// File: rtl/apu_dma_fsm.sv
// State register and next-state logic of the DMA sequencer. The state is
// exported as a plain vector; all output decoding lives in the top.
module apu_dma_fsm
    import apu_dma_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_aclk,
    input  logic       i_rnw_cpu,
    input  logic       i_spr_pend,
    input  logic       i_spr_start,
    input  logic       i_dmc_ok,
    input  logic       i_cnt_last,
    output logic [2:0] o_state
);

    dma_state_t r_state;
    dma_state_t w_next;
    logic       w_pend;

    // A $4014 write accepted this cycle counts as pending right away, so a
    // DPCM-only sequence flows straight into the sprite copy without a new HALT.
    assign w_pend = i_spr_pend | i_spr_start;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pend || i_dmc_ok)
                    w_next = HALT;
            end
            HALT: begin
                // CPU write cycles cannot be halted; wait for a read.
                if (i_rnw_cpu)
                    w_next = i_aclk ? ALIGN : read_choice(i_dmc_ok, w_pend);
            end
            ALIGN:   w_next = read_choice(i_dmc_ok, w_pend);
            SPR_RD:  w_next = SPR_WR;
            SPR_WR:  w_next = read_choice(i_dmc_ok, w_pend && !i_cnt_last);
            DMC_RD:  w_next = w_pend ? ALIGN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/apu_dma_arbiter.sv
// APU bus-master sequencer: halts the CPU and performs sprite OAM copies
// and DPCM sample fetches on the CPU bus, aligned to the get/put phase.
module apu_dma_arbiter
    import apu_dma_pkg::*;
(
    input  logic        PHI1,
    input  logic        RES,
    input  logic        ACLK,
    input  logic        RnW_cpu,
    input  logic        W4014,
    input  logic [7:0]  DB_in,
    input  logic        DMC_req,
    input  logic [15:0] DMC_Addr,
    output logic        DMC_ack,
    output logic        CPU_RDY,
    output logic        DMA_active,
    output logic [15:0] A_out,
    output logic        RnW_out,
    output logic [7:0]  D_out,
    output logic        SPR_busy
);

    logic [7:0] r_page;
    logic [7:0] r_cnt;
    logic [7:0] r_buf;
    logic       r_spr_pend;
    logic       r_dmc_mask;

    logic [2:0] w_state_raw;
    dma_state_t w_state;
    logic       w_dmc_ok;
    logic       w_spr_start;
    logic       w_cnt_last;

    // The mask hides DMC_req for the cycle after the ack, giving the
    // requester one cycle to drop it.
    assign w_dmc_ok    = DMC_req && !r_dmc_mask;
    assign w_spr_start = W4014 && !r_spr_pend;
    assign w_cnt_last  = (r_cnt == SPR_LAST);
    assign w_state     = dma_state_t'(w_state_raw);

    apu_dma_fsm u_fsm (
        .i_clk       (PHI1),
        .i_rst       (RES),
        .i_aclk      (ACLK),
        .i_rnw_cpu   (RnW_cpu),
        .i_spr_pend  (r_spr_pend),
        .i_spr_start (w_spr_start),
        .i_dmc_ok    (w_dmc_ok),
        .i_cnt_last  (w_cnt_last),
        .o_state     (w_state_raw)
    );

    always_ff @(posedge PHI1) begin
        if (RES) begin
            r_page     <= 8'h00;
            r_cnt      <= 8'h00;
            r_buf      <= 8'h00;
            r_spr_pend <= 1'b0;
            r_dmc_mask <= 1'b0;
        end else begin
            r_dmc_mask <= (w_state == DMC_RD);
            if (w_spr_start) begin
                r_page     <= DB_in;
                r_cnt      <= 8'h00;
                r_spr_pend <= 1'b1;
            end
            if (w_state == SPR_RD)
                r_buf <= DB_in;
            if (w_state == SPR_WR) begin
                r_cnt <= r_cnt + 8'd1;
                if (w_cnt_last)
                    r_spr_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        CPU_RDY    = 1'b1;
        DMA_active = 1'b0;
        A_out      = 16'h0000;
        RnW_out    = 1'b1;
        D_out      = 8'h00;
        DMC_ack    = 1'b0;
        case (w_state)
            HALT, ALIGN: begin
                CPU_RDY = 1'b0;
            end
            SPR_RD: begin
                CPU_RDY    = 1'b0;
                DMA_active = 1'b1;
                A_out      = {r_page, r_cnt};
            end
            SPR_WR: begin
                CPU_RDY    = 1'b0;
                DMA_active = 1'b1;
                A_out      = OAMDATA_ADDR;
                RnW_out    = 1'b0;
                D_out      = r_buf;
            end
            DMC_RD: begin
                CPU_RDY    = 1'b0;
                DMA_active = 1'b1;
                A_out      = DMC_Addr;
                DMC_ack    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign SPR_busy = r_spr_pend;

endmodule

// File: tb/tb_apu_dma_arbiter.sv
// Scoreboard bench for apu_dma_arbiter: stimulus queues the expected bus
// transactions, a negedge monitor pops and compares each DMA cycle.
module tb_apu_dma_arbiter;

    logic        PHI1 = 1'b0;
    logic        RES, ACLK, RnW_cpu, W4014, DMC_req;
    logic [7:0]  DB_in, db_cpu;
    logic [15:0] DMC_Addr;
    logic        DMC_ack, CPU_RDY, DMA_active, RnW_out, SPR_busy;
    logic [15:0] A_out;
    logic [7:0]  D_out;

    typedef struct packed {
        logic [15:0] a;
        logic        rnw;
        logic [7:0]  d;
        logic        ack;
        logic        ph;
    } xact_t;

    xact_t q[$];
    xact_t mon_exp, mon_got;
    int    errors = 0;
    int    checks = 0;

    always #5 PHI1 = ~PHI1;

    // Memory model: every byte at address a holds a[7:0]^0x5A.
    assign DB_in = (DMA_active && RnW_out) ? (A_out[7:0] ^ 8'h5A) : db_cpu;

    apu_dma_arbiter dut (
        .PHI1       (PHI1),
        .RES        (RES),
        .ACLK       (ACLK),
        .RnW_cpu    (RnW_cpu),
        .W4014      (W4014),
        .DB_in      (DB_in),
        .DMC_req    (DMC_req),
        .DMC_Addr   (DMC_Addr),
        .DMC_ack    (DMC_ack),
        .CPU_RDY    (CPU_RDY),
        .DMA_active (DMA_active),
        .A_out      (A_out),
        .RnW_out    (RnW_out),
        .D_out      (D_out),
        .SPR_busy   (SPR_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge PHI1) begin
        if (DMA_active === 1'b1) begin
            mon_got = {A_out, RnW_out, D_out, DMC_ack, ACLK};
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xact: got %0h expected none", mon_got);
            end else begin
                mon_exp = q.pop_front();
                chk("xact", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic cyc();
        @(posedge PHI1);
        #1;
        ACLK = ~ACLK;
    endtask

    task automatic push_spr(input logic [7:0] pg, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            q.push_back({pg, 8'(i), 1'b1, 8'h00, 1'b0, 1'b1});
            q.push_back({16'h2004, 1'b0, 8'(i) ^ 8'h5A, 1'b0, 1'b0});
        end
    endtask

    task automatic push_dmc();
        q.push_back({16'hC123, 1'b1, 8'h00, 1'b1, 1'b1});
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_rdy"},    32'(CPU_RDY),    32'd1);
        chk({nm, "_active"}, 32'(DMA_active), 32'd0);
        chk({nm, "_addr"},   32'(A_out),      32'd0);
        chk({nm, "_rnw"},    32'(RnW_out),    32'd1);
        chk({nm, "_dout"},   32'(D_out),      32'd0);
        chk({nm, "_ack"},    32'(DMC_ack),    32'd0);
        chk({nm, "_busy"},   32'(SPR_busy),   32'd0);
    endtask

    // W4014 is issued in a cycle whose ACLK equals ph; k counts cycles after it.
    task automatic run_spr(input string nm, input logic [7:0] pg, input logic ph,
                           input int nwr, input int dmc_at, input int res_at,
                           input int exp_low);
        int low;
        bit done;
        low  = 0;
        done = 0;
        cyc();
        if (ACLK != ph) cyc();
        W4014  = 1'b1;
        db_cpu = pg;
        for (int k = 1; k <= 1200 && !done; k++) begin
            cyc();
            W4014   = 1'b0;
            db_cpu  = 8'h00;
            RnW_cpu = (k <= nwr) ? 1'b0 : 1'b1;
            DMC_req = (dmc_at > 0 && (k == dmc_at || k == dmc_at + 1));
            RES     = (res_at > 0 && k == res_at);
            @(negedge PHI1);
            if (k == 1) begin
                chk({nm, "_rdy_fall"}, 32'(CPU_RDY), 32'd0);
                chk({nm, "_busy_set"}, 32'(SPR_busy), 32'd1);
            end
            if (res_at > 0 && k == res_at + 1) begin
                check_idle({nm, "_abort"});
                done = 1;
            end else if (!CPU_RDY) begin
                low++;
            end else if (low > 0) begin
                done = 1;
                chk({nm, "_busy_clr"}, 32'(SPR_busy), 32'd0);
            end
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        if (res_at == 0)
            chk({nm, "_rdy_low"}, 32'(low), 32'(exp_low));
    endtask

    task automatic run_dmc(input string nm, input logic ph, input int exp_low);
        int low;
        bit done;
        low  = 0;
        done = 0;
        cyc();
        if (ACLK != ph) cyc();
        push_dmc();
        DMC_req = 1'b1;
        for (int k = 1; k <= 20 && !done; k++) begin
            cyc();
            DMC_req = (k <= exp_low);
            @(negedge PHI1);
            if (!CPU_RDY)
                low++;
            else if (low > 0)
                done = 1;
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_rdy_low"}, 32'(low), 32'(exp_low));
    endtask

    initial begin
        RES      = 1'b1;
        W4014    = 1'b1;
        db_cpu   = 8'h77;
        ACLK     = 1'b0;
        RnW_cpu  = 1'b1;
        DMC_req  = 1'b0;
        DMC_Addr = 16'hC123;
        repeat (3) cyc();
        RES   = 1'b0;
        W4014 = 1'b0;
        @(negedge PHI1);
        check_idle("reset");
        cyc();
        @(negedge PHI1);
        check_idle("res_wins");

        push_spr(8'h02, 0, 255);
        run_spr("spr_p2_get", 8'h02, 1'b1, 0, 0, 0, 513);
        push_spr(8'h03, 0, 255);
        run_spr("spr_p3_put", 8'h03, 1'b0, 0, 0, 0, 514);
        push_spr(8'h04, 0, 255);
        run_spr("wr_hold_get", 8'h04, 1'b1, 3, 0, 0, 517);
        push_spr(8'h04, 0, 255);
        run_spr("wr_hold_put", 8'h04, 1'b0, 3, 0, 0, 516);

        run_dmc("dmc_idle_a", 1'b1, 2);
        run_dmc("dmc_idle_b", 1'b0, 3);

        push_spr(8'h03, 0, 63);
        push_dmc();
        push_spr(8'h03, 64, 255);
        run_spr("dmc_mid", 8'h03, 1'b1, 0, 129, 0, 515);

        push_spr(8'h03, 0, 127);
        q.push_back({16'h0380, 1'b1, 8'h00, 1'b0, 1'b1});
        run_spr("res_mid", 8'h03, 1'b1, 0, 0, 258, 0);
        push_spr(8'h05, 0, 255);
        run_spr("restart_p5", 8'h05, 1'b0, 0, 0, 0, 514);

        repeat (4) cyc();
        @(negedge PHI1);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
